// File: rtl/traceback_reader.sv
// traceback_reader
//   Walks the direction memory written by the systolic PE array back from the
//   max-score cell and streams the alignment ops (M/I/D) in reverse order to
//   the CIGAR packer. Only one traceback runs at a time.
//
// Ports
//   clk, reset_i            clock, synchronous active-high reset
//   start_i                 begin a traceback at (max_x_i, max_y_i), 1-based
//   rd_en_o, rd_x_o, rd_y_o direction memory read request (one outstanding)
//   rd_data_i               direction word, valid one cycle after rd_en_o
//   op_o, op_valid_o        op stream (0=M, 1=I, 2=D), held until op_ready_i
//   op_ready_i              downstream accept
//   busy_o, done_o          walk in progress / one-cycle completion pulse
//   end_x_o, end_y_o        cell where the walk stopped
//   op_cnt_o                ops emitted in the current/last walk (saturating)
module traceback_reader #(
    parameter int ADDR_W = 10,
    parameter int DIR_W  = 5,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] max_x_i,
    input  logic [ADDR_W-1:0] max_y_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_x_o,
    output logic [ADDR_W-1:0] rd_y_o,
    input  logic [DIR_W-1:0]  rd_data_i,
    output logic [1:0]        op_o,
    output logic              op_valid_o,
    input  logic              op_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] end_x_o,
    output logic [ADDR_W-1:0] end_y_o,
    output logic [CNT_W-1:0]  op_cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_DECODE, S_EMIT, S_DONE} state_t;
    typedef enum logic [2:0] {G_H, G_F, G_FH, G_E, G_EH} gap_t;

    localparam logic [1:0] OP_M = 2'd0;
    localparam logic [1:0] OP_I = 2'd1;
    localparam logic [1:0] OP_D = 2'd2;

    // Gap-entry codes (d[4]=0). Any other code with d[4]=0 ends the walk.
    localparam logic [DIR_W-1:0] W_F  = DIR_W'(5'b00111);
    localparam logic [DIR_W-1:0] W_FH = DIR_W'(5'b01111);
    localparam logic [DIR_W-1:0] W_E  = DIR_W'(5'b00011);
    localparam logic [DIR_W-1:0] W_EH = DIR_W'(5'b01011);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            r_state;
    gap_t              r_gap;
    logic [ADDR_W-1:0] r_x, r_y;
    logic [ADDR_W-1:0] r_nx, r_ny;     // coordinates applied once the op is accepted
    logic [DIR_W-1:0]  r_dir;
    logic [1:0]        r_op;
    logic              r_op_valid;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_end_x, r_end_y;
    logic [CNT_W-1:0]  r_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_gap      <= G_H;
            r_x        <= '0;
            r_y        <= '0;
            r_op       <= OP_M;
            r_op_valid <= 1'b0;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_end_x    <= '0;
            r_end_y    <= '0;
            r_cnt      <= '0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_x    <= max_x_i;
                        r_y    <= max_y_i;
                        r_cnt  <= '0;
                        r_gap  <= G_H;
                        r_busy <= 1'b1;
                        if (max_x_i == '0 || max_y_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_end_x <= max_x_i;
                            r_end_y <= max_y_i;
                        end else begin
                            r_state <= S_READ;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                S_READ: r_state <= S_WAIT;
                S_WAIT: begin
                    r_dir   <= rd_data_i;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    case (r_gap)
                        G_H: begin
                            if (r_dir[4]) begin
                                r_op       <= OP_M;
                                r_nx       <= r_x - ONE;
                                r_ny       <= r_y - ONE;
                                r_op_valid <= 1'b1;
                                r_state    <= S_EMIT;
                            end else if (r_dir == W_F) begin
                                r_gap <= G_F;       // re-decode same word in gap state
                            end else if (r_dir == W_FH) begin
                                r_gap <= G_FH;
                            end else if (r_dir == W_E) begin
                                r_gap <= G_E;
                            end else if (r_dir == W_EH) begin
                                r_gap <= G_EH;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_end_x <= r_x;
                                r_end_y <= r_y;
                            end
                        end
                        G_F, G_FH: begin
                            r_op       <= OP_I;
                            r_nx       <= r_x;
                            r_ny       <= r_y - ONE;
                            r_op_valid <= 1'b1;
                            r_state    <= S_EMIT;
                            if (!((r_gap == G_F) ? r_dir[3] : r_dir[1]))
                                r_gap <= G_H;
                        end
                        G_E, G_EH: begin
                            r_op       <= OP_D;
                            r_nx       <= r_x - ONE;
                            r_ny       <= r_y;
                            r_op_valid <= 1'b1;
                            r_state    <= S_EMIT;
                            if (!((r_gap == G_E) ? r_dir[2] : r_dir[0]))
                                r_gap <= G_H;
                        end
                        default: r_gap <= G_H;
                    endcase
                end
                S_EMIT: begin
                    if (op_ready_i) begin
                        r_op_valid <= 1'b0;
                        r_cnt      <= sat_inc(r_cnt);
                        r_x        <= r_nx;
                        r_y        <= r_ny;
                        // Stop on reaching row/column 0 so coordinates never wrap.
                        if (r_nx == '0 || r_ny == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_end_x <= r_nx;
                            r_end_y <= r_ny;
                        end else begin
                            r_state <= S_READ;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_en_o    = r_rd_en;
    assign rd_x_o     = r_x;
    assign rd_y_o     = r_y;
    assign op_o       = r_op;
    assign op_valid_o = r_op_valid;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign end_x_o    = r_end_x;
    assign end_y_o    = r_end_y;
    assign op_cnt_o   = r_cnt;

endmodule
